brnch_pred_pht_nbit: RTL

Parametrised dynamic branch predictor with a PC-indexed pattern history table (PHT) of N-bit saturating counters and optional gshare global-history indexing. Looks up a prediction for the branch in IF and carries it to ID in an internal pipeline register. When the ID-stage comparison result arrives, it trains the counter, raises `flush` on mispredict, and keeps branch/mispredict performance counts. Sits beside the ID-stage hazard/forwarding logic of the 5-stage MIPS pipeline, which supplies `stall` and `id_taken`.

---
 rtl/brnch_pred_pht_nbit_pkg.sv | 28 ++
 rtl/brnch_pred_pht_nbit_if.sv | 27 ++
 rtl/brnch_pht.sv | 47 ++++
 rtl/brnch_pred_pht_nbit.sv | 109 ++++++++++
 4 files changed

// File: rtl/brnch_pred_pht_nbit_pkg.sv
// Shared definitions for the N-bit PHT branch predictor.
//   BR_OPCODE  : opcode of the conditional branch decoded upstream in IF
//   sat_inc    : saturating increment of a w-bit counter held in 32 bits
//   sat_dec    : saturating decrement of a w-bit counter held in 32 bits
//   ctr_init   : weakly-not-taken reset value for a w-bit counter
package brnch_pred_pkg;

  localparam logic [5:0] BR_OPCODE = 6'b000100;

  function automatic logic [31:0] ctr_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = ctr_max(w);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
    return (v == 32'd0) ? 32'd0 : ((v - 32'd1) & ctr_max(w));
  endfunction

  function automatic logic [31:0] ctr_init(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/brnch_pred_pht_nbit_if.sv
// Predictor <-> pipeline signal bundle.
//   master : pipeline side, drives IF branch/PC, stall and resolved outcome
//   slave  : predictor side, returns predictions, flush and perf counts
interface brnch_pred_pht_nbit_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             if_br_valid;
  logic [PC_W-1:0]  if_pc;
  logic             stall;
  logic             id_taken;
  logic             pred_taken;
  logic             id_pred_taken;
  logic             flush;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_br_valid, if_pc, stall, id_taken,
    input  pred_taken, id_pred_taken, flush, br_cnt, mispred_cnt
  );

  modport slave (
    input  if_br_valid, if_pc, stall, id_taken,
    output pred_taken, id_pred_taken, flush, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/brnch_pht.sv
// Pattern history table of 2^IDX_W saturating counters.
//   clk, rst   : clock, synchronous active-high reset (all entries weakly-not-taken)
//   rd_idx/ctr : combinational read port
//   wr_*       : write port; on wr_en the entry moves one step toward wr_taken
module brnch_pht
  import brnch_pred_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int unsigned     Entries = 1 << IDX_W;
  localparam logic [31:0]     InitW   = ctr_init(CTR_W);
  localparam logic [CTR_W-1:0] Init   = InitW[CTR_W-1:0];

  logic [CTR_W-1:0] ctr_q [Entries];
  logic [31:0]      cur_w;
  logic [31:0]      nxt_w;
  logic [CTR_W-1:0] wr_next;
  logic             unused_nxt;

  // No write-to-read bypass: a same-cycle lookup sees the pre-update value.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    cur_w   = 32'(ctr_q[wr_idx]);
    nxt_w   = wr_taken ? sat_inc(cur_w, CTR_W) : sat_dec(cur_w, CTR_W);
    wr_next = nxt_w[CTR_W-1:0];
  end

  assign unused_nxt = ^nxt_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) ctr_q[i] <= Init;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= wr_next;
    end
  end
endmodule

// File: rtl/brnch_pred_pht_nbit.sv
// Dynamic branch predictor: PC-indexed PHT with optional gshare hashing.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of brnch_pred_pht_nbit_if (IF lookup, ID resolve,
//              flush on mispredict, branch / mispredict counts)
// The prediction made in IF travels with the branch into ID; the ID outcome
// trains the counter and the (non-speculative) global history.
module brnch_pred_pht_nbit
  import brnch_pred_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CTR_W = 2,
  parameter int unsigned GHR_W = 0,
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  brnch_pred_pht_nbit_if.slave bus
);
  logic [IDX_W-1:0] hist;
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] rd_ctr;
  logic             pred;

  logic             id_valid_q;
  logic [IDX_W-1:0] id_idx_q;
  logic             id_pred_q;

  logic             res;
  logic             mispred;
  logic             flush;

  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic             unused_pc;

  assign unused_pc = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0]};

  if (GHR_W > 0) begin : g_gshare
    logic [GHR_W-1:0] ghr_q;

    always_comb begin
      hist = '0;
      for (int i = 0; i < GHR_W; i++) hist[i] = ghr_q[i];
    end

    // Shifted only by resolved branches, so lookups never see wrong-path history.
    always_ff @(posedge clk) begin
      if (rst) begin
        ghr_q <= '0;
      end else if (res) begin
        ghr_q[0] <= bus.id_taken;
        for (int i = 1; i < GHR_W; i++) ghr_q[i] <= ghr_q[i-1];
      end
    end
  end else begin : g_bimodal
    assign hist = '0;
  end

  assign idx  = bus.if_pc[IDX_W+1:2] ^ hist;
  assign pred = rd_ctr[CTR_W-1];

  // rst gates resolution so an in-flight ID branch is dropped silently.
  assign res     = id_valid_q & ~bus.stall & ~rst;
  assign mispred = bus.id_taken != id_pred_q;
  assign flush   = res & mispred;

  brnch_pht #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (res),
    .wr_idx   (id_idx_q),
    .wr_taken (bus.id_taken)
  );

  // A branch fetched during a flush is on the wrong path and never reaches ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_idx_q   <= '0;
      id_pred_q  <= 1'b0;
    end else if (!bus.stall) begin
      id_valid_q <= bus.if_br_valid & ~flush;
      id_idx_q   <= idx;
      id_pred_q  <= pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (res) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign bus.pred_taken    = bus.if_br_valid & pred & ~bus.stall;
  assign bus.id_pred_taken = id_valid_q & id_pred_q;
  assign bus.flush         = flush;
  assign bus.br_cnt        = br_cnt_q;
  assign bus.mispred_cnt   = mispred_cnt_q;
endmodule
